sync_fifo_core: RTL and testbench
=================================

Name: sync_fifo_core

Overview:
Single-clock synchronous FIFO. This is the storage stage the FIFO bench monitor observes: it accepts words on data_in under wr_en and returns them in order on data_out under rd_en. It reports occupancy (full, empty, almostfull, almostempty) and per-cycle operation status (wr_ack, overflow, underflow). Status outputs are defined so a negedge-sampling monitor sees stable, cycle-exact values.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1).
FIFO_DEPTH, 8, number of storage entries (>=4, any integer; power of two not required).

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
data_in  input  FIFO_WIDTH  write data.
wr_en  input  1  write request.
rd_en  input  1  read request.
data_out  output  FIFO_WIDTH  read data, registered.
wr_ack  output  1  registered; previous-edge write accepted.
overflow  output  1  registered; previous-edge write rejected (FIFO full).
underflow  output  1  registered; previous-edge read rejected (FIFO empty).
full  output  1  combinational; count == FIFO_DEPTH.
empty  output  1  combinational; count == 0.
almostfull  output  1  combinational; count == FIFO_DEPTH-1.
almostempty  output  1  combinational; count == 1.

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0. This gives empty=1 and full=almostfull=almostempty=0. Memory contents are not cleared. Reset asserted mid-operation discards all stored words immediately, without waiting for a clock edge.
- State: memory[FIFO_DEPTH], wr_ptr/rd_ptr of width $clog2(FIFO_DEPTH), count of width $clog2(FIFO_DEPTH)+1.
- Pointers increment by 1 per accepted op and wrap from FIFO_DEPTH-1 to 0 by explicit compare, not modulo-2^n.
- Write accepted at posedge iff wr_en && !full. On accept: memory[wr_ptr] <= data_in, wr_ptr advances, wr_ack <= 1, overflow <= 0.
- Write rejected at posedge if wr_en && full: wr_ack <= 0, overflow <= 1. Memory and wr_ptr are unchanged.
- No write request (wr_en=0): wr_ack <= 0, overflow <= 0.
- Read accepted at posedge iff rd_en && !empty. On accept: data_out <= memory[rd_ptr], rd_ptr advances, underflow <= 0.
- Read rejected at posedge if rd_en && empty: underflow <= 1; data_out holds its value.
- No read request (rd_en=0): underflow <= 0; data_out holds.
- count update per edge: +1 if write-only accepted; -1 if read-only accepted; unchanged if both accepted or neither.
- Simultaneous wr_en && rd_en:
  - not full and not empty: both accepted, count unchanged.
  - empty: write accepted, read rejected (underflow=1), count +1. No write-through: data_out does not return the word being written.
  - full: read accepted, write rejected (overflow=1), count -1.
- Latency:
  - A word written at edge k raises count at edge k; empty deasserts after edge k; the word is readable by rd_en at edge k+1.
  - data_out is valid after the accepting read edge and holds until the next accepted read.
- Flags are combinational from count only, so they never glitch between edges.
- wr_ack, overflow and underflow each pulse one cycle per qualifying edge.
- No X on any output after reset, regardless of input values.

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, almostfull=0, almostempty=0, data_out=0, wr_ack=overflow=underflow=0.
- Write 0x0001..0x0008 (8 cycles, rd_en=0):
  - wr_ack=1 each cycle.
  - almostempty=1 after the 1st write, almostfull=1 after the 7th, full=1 after the 8th.
  - A 9th write of 0xDEAD -> overflow=1, wr_ack=0, count stays 8.
- From full, read 8 cycles -> data_out = 0x0001..0x0008 in order, empty=1 after the last read. A 9th read -> underflow=1, data_out holds 0x0008.
- From empty, wr_en=rd_en=1 with data_in=0x00AA:
  - underflow=1, wr_ack=1, count=1.
  - Next cycle both again with 0x00BB -> data_out=0x00AA, count stays 1.
- Wrap-around: 5 writes, 5 reads, then 8 writes 0x0100..0x0107 and 8 reads -> data_out = 0x0100..0x0107 in order; full=1 between the phases.
- Load 4 words, assert rst_n=0 asynchronously mid-cycle for 1 ns -> empty=1 and data_out=0 immediately. Next write of 0x0055 then read -> data_out=0x0055.

Source files
------------

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with registered read data, registered per-edge op status and count-decoded flags.
// Latency: a word written at edge k is readable at edge k+1; data_out updates on the accepting read edge.
// Backpressure: writes into a full FIFO are dropped (overflow), reads from an empty FIFO are dropped (underflow).
module sync_fifo_core #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [AW-1:0] PTR_LAST    = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ALMOSTF = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_accept;
    logic rd_accept;

    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q == CNT_ALMOSTF);
    assign almostempty = (count_q == CNT_ONE);

    assign data_out  = data_out_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Acceptance uses the pre-edge flags, so a read on empty never sees the concurrent write.
    always_comb begin
        wr_accept   = wr_en && !full;
        rd_accept   = rd_en && !empty;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        wr_ack_d    = wr_accept;
        overflow_d  = wr_en && full;
        underflow_d = rd_en && empty;

        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end

        if (rd_accept) begin
            rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; only words behind rd_ptr are ever read.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed plus randomized bench for sync_fifo_core, checked against a queue-based model at each negedge.
module tb_sync_fifo_core;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data_in;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         wr_ack;
    logic         overflow;
    logic         underflow;
    logic         full;
    logic         empty;
    logic         almostfull;
    logic         almostempty;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: FIFO contents as a queue plus the last registered outputs.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout;
    logic         m_ack;
    logic         m_ovf;
    logic         m_udf;

    sync_fifo_core #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .wr_ack     (wr_ack),
        .overflow   (overflow),
        .underflow  (underflow),
        .full       (full),
        .empty      (empty),
        .almostfull (almostfull),
        .almostempty(almostempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string ctx);
        chk({ctx, ".data_out"},    32'(data_out),    32'(m_dout));
        chk({ctx, ".wr_ack"},      32'(wr_ack),      32'(m_ack));
        chk({ctx, ".overflow"},    32'(overflow),    32'(m_ovf));
        chk({ctx, ".underflow"},   32'(underflow),   32'(m_udf));
        chk({ctx, ".full"},        32'(full),        32'(mq.size() == D));
        chk({ctx, ".empty"},       32'(empty),       32'(mq.size() == 0));
        chk({ctx, ".almostfull"},  32'(almostfull),  32'(mq.size() == D - 1));
        chk({ctx, ".almostempty"}, 32'(almostempty), 32'(mq.size() == 1));
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Drive one cycle of requests, advance the model at the edge, compare at the following negedge.
    task automatic step(input logic we, input logic re, input logic [W-1:0] din, input string ctx);
        bit was_full;
        bit was_empty;
        wr_en   = we;
        rd_en   = re;
        data_in = din;
        @(posedge clk);
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        if (re && !was_empty) m_dout = mq.pop_front();
        if (we && !was_full)  mq.push_back(din);
        m_ack = we && !was_full;
        m_ovf = we && was_full;
        m_udf = re && was_empty;
        @(negedge clk);
        check_model(ctx);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        check_model("reset");

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, "idle");

        // Fill to full, then one write too many.
        for (int i = 1; i <= D; i++) begin
            step(1'b1, 1'b0, W'(i), "fill");
            chk("fill.wr_ack", 32'(wr_ack), 32'd1);
            if (i == 1)     chk("fill.almostempty_1st", 32'(almostempty), 32'd1);
            if (i == D - 1) chk("fill.almostfull_7th",  32'(almostfull),  32'd1);
        end
        chk("fill.full_8th", 32'(full), 32'd1);
        step(1'b1, 1'b0, 16'hDEAD, "ovf");
        chk("ovf.overflow", 32'(overflow), 32'd1);
        chk("ovf.wr_ack",   32'(wr_ack),   32'd0);
        chk("ovf.still_full", 32'(full),   32'd1);

        // Drain in order, then one read too many.
        for (int i = 1; i <= D; i++) begin
            step(1'b0, 1'b1, '0, "drain");
            chk("drain.order", 32'(data_out), 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, '0, "udf");
        chk("udf.underflow", 32'(underflow), 32'd1);
        chk("udf.hold",      32'(data_out),  32'h0008);

        // Simultaneous read/write starting from empty: no write-through.
        step(1'b1, 1'b1, 16'h00AA, "rw_empty");
        chk("rw_empty.underflow",   32'(underflow),   32'd1);
        chk("rw_empty.wr_ack",      32'(wr_ack),      32'd1);
        chk("rw_empty.almostempty", 32'(almostempty), 32'd1);
        chk("rw_empty.no_thru",     32'(data_out),    32'h0008);
        step(1'b1, 1'b1, 16'h00BB, "rw_both");
        chk("rw_both.data_out",    32'(data_out),    32'h00AA);
        chk("rw_both.almostempty", 32'(almostempty), 32'd1);
        step(1'b0, 1'b1, '0, "rw_drain");
        chk("rw_drain.data_out", 32'(data_out), 32'h00BB);

        // Pointer wrap-around.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(16'h0050 + i), "wrap_pre_w");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, "wrap_pre_r");
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(16'h0100 + i), "wrap_w");
        chk("wrap.full", 32'(full), 32'd1);
        // Full with both requests: read wins, write is rejected.
        step(1'b1, 1'b1, 16'hBEEF, "rw_full");
        chk("rw_full.overflow", 32'(overflow), 32'd1);
        chk("rw_full.data_out", 32'(data_out), 32'h0100);
        chk("rw_full.almostfull", 32'(almostfull), 32'd1);
        for (int i = 1; i < D; i++) begin
            step(1'b0, 1'b1, '0, "wrap_r");
            chk("wrap.order", 32'(data_out), 32'(16'h0100 + i));
        end

        // Asynchronous reset pulse between edges.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'(16'h0A00 + i), "pre_rst");
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.empty",    32'(empty),    32'd1);
        chk("arst.data_out", 32'(data_out), 32'd0);
        check_model("arst");
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h0055, "post_rst_w");
        step(1'b0, 1'b1, '0, "post_rst_r");
        chk("post_rst.data_out", 32'(data_out), 32'h0055);

        // Randomized traffic with phases biased towards filling and draining.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step(($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5))),
                 ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5))),
                 W'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
